// File: rtl/nios_system_pio_in_edge.sv
// Avalon-MM input PIO: per-bit synchroniser, optional debounce, sticky edge
// capture with write-1-to-clear, and a maskable registered level interrupt.
module nios_system_pio_in_edge #(
  parameter int unsigned DATA_WIDTH      = 18,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned ARM_CYCLES      = SYNC_STAGES + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  localparam int unsigned ARM_W = (ARM_CYCLES > 0) ? $clog2(ARM_CYCLES + 1) : 1;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] w_sync_q;
  logic [DATA_WIDTH-1:0] w_deb;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] r_irqmask;
  logic [DATA_WIDTH-1:0] r_edgecap;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [ARM_W-1:0]      r_arm_cnt;
  logic                  w_armed;
  logic                  w_wr;
  logic [31:0]           w_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_armed  = (r_arm_cnt == ARM_W'(ARM_CYCLES));

  always_ff @(posedge clk) begin
    if (reset)         r_arm_cnt <= '0;
    else if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_deb
      assign w_deb = w_sync_q;
    end else begin : g_deb
      logic [DATA_WIDTH-1:0] r_deb;
      logic [CNT_W-1:0]      r_cnt [DATA_WIDTH];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_deb <= '0;
          for (int unsigned i = 0; i < DATA_WIDTH; i++) r_cnt[i] <= '0;
        end else if (!w_armed) begin
          r_deb <= w_sync_q;
          for (int unsigned i = 0; i < DATA_WIDTH; i++) r_cnt[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (w_sync_q[i] == r_deb[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              r_cnt[i] <= '0;
              r_deb[i] <= w_sync_q[i];
            end else begin
              r_cnt[i] <= r_cnt[i] + 1'b1;
            end
          end
        end
      end

      assign w_deb = r_deb;
    end

    if (DATA_WIDTH < 32) begin : g_wd_hi
      logic w_unused_wd;
      assign w_unused_wd = ^writedata[31:DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    w_edge = '0;
    if (w_armed) begin
      case (EDGE_TYPE)
        0:       w_edge = w_deb & ~r_prev;
        1:       w_edge = ~w_deb & r_prev;
        default: w_edge = w_deb ^ r_prev;
      endcase
    end
  end

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == 2'd3) ? writedata[DATA_WIDTH-1:0] : '0;

  always_comb begin
    w_rd = '0;
    case (address)
      2'd0:    w_rd[DATA_WIDTH-1:0] = w_deb;
      2'd2:    w_rd[DATA_WIDTH-1:0] = r_irqmask;
      2'd3:    w_rd[DATA_WIDTH-1:0] = r_edgecap;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev    <= '0;
      r_edgecap <= '0;
      r_irqmask <= '0;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      // While unarmed prev follows what deb is loading, so deb==prev on the first armed cycle
      r_prev    <= w_armed ? w_deb : w_sync_q;
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr && address == 2'd2) r_irqmask <= writedata[DATA_WIDTH-1:0];
      irq       <= |(r_edgecap & r_irqmask);
      readdata  <= w_rd;
    end
  end

endmodule

// File: tb/tb_nios_system_pio_in_edge.sv
// Directed bench: three instances (defaults, debounce=4, 8-bit any-edge) on a shared bus.
module tb_nios_system_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [17:0] in0, in1;
  logic [7:0]  in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  nios_system_pio_in_edge u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0));

  nios_system_pio_in_edge #(.DEBOUNCE_CYCLES(4)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1));

  nios_system_pio_in_edge #(.DATA_WIDTH(8), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2));

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
  endtask

  task automatic test_reset;
    logic seen;
    reset = 1'b1; in0 = 18'h3FFFF; in1 = '0; in2 = '0;
    tick(3);
    total++;
    if (rd0 !== 32'h0 || irq0 !== 1'b0) $display("FAIL reset_vals readdata=%h irq=%b want 0/0", rd0, irq0);
    else pass_cnt++;
    reset = 1'b0;
    wr(2'd2, 32'h0003FFFF);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (irq0 !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL reset_no_irq irq seen=%b want 0", seen);
    else pass_cnt++;
    rd(2'd3);
    total++;
    if (rd0 !== 32'h0) $display("FAIL reset_no_capture got=%h want 00000000", rd0);
    else pass_cnt++;
    rd(2'd0);
    total++;
    if (rd0 !== 32'h0003FFFF) $display("FAIL reset_data got=%h want 0003ffff", rd0);
    else pass_cnt++;
  endtask

  task automatic test_rising;
    in0 = '0;
    do_reset();
    wr(2'd2, 32'h1);
    address = 2'd3;
    tick();
    in0[0] = 1'b1;
    tick(3);
    total++;
    if (irq0 !== 1'b0) $display("FAIL rise_irq_early got=%b want 0", irq0);
    else pass_cnt++;
    tick();
    total++;
    if (rd0 !== 32'h1 || irq0 !== 1'b1) $display("FAIL rise_capture cap=%h irq=%b want 1/1", rd0, irq0);
    else pass_cnt++;
    wr(2'd3, 32'h1);
    total++;
    if (irq0 !== 1'b1) $display("FAIL clr_irq_hold got=%b want 1", irq0);
    else pass_cnt++;
    tick();
    total++;
    if (irq0 !== 1'b0 || rd0 !== 32'h0) $display("FAIL clr_irq_fall irq=%b cap=%h want 0/0", irq0, rd0);
    else pass_cnt++;
    in0[0] = 1'b0;
    tick(6);
    rd(2'd3);
    total++;
    if (rd0 !== 32'h0 || irq0 !== 1'b0) $display("FAIL fall_ignored cap=%h irq=%b want 0/0", rd0, irq0);
    else pass_cnt++;
  endtask

  task automatic test_set_clear_collision;
    in0[5] = 1'b1;
    tick(5);
    in0[5] = 1'b0;
    tick(5);
    rd(2'd3);
    total++;
    if (rd0 !== 32'h20) $display("FAIL collide_pre got=%h want 00000020", rd0);
    else pass_cnt++;
    in0[5] = 1'b1;
    tick(2);
    wr(2'd3, 32'h20);
    tick(2);
    rd(2'd3);
    total++;
    if (rd0 !== 32'h20) $display("FAIL collide_set_wins got=%h want 00000020", rd0);
    else pass_cnt++;
    wr(2'd3, 32'h20);
    rd(2'd3);
    total++;
    if (rd0 !== 32'h0) $display("FAIL collide_later_clear got=%h want 0", rd0);
    else pass_cnt++;
  endtask

  task automatic test_debounce;
    logic seen;
    in0 = '0; in1 = '0;
    do_reset();
    address = 2'd0;
    in1[2] = 1'b1;
    tick(3);
    in1[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rd1 !== 32'h0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL deb_short_data changed=%b want 0", seen);
    else pass_cnt++;
    rd(2'd3);
    total++;
    if (rd1 !== 32'h0) $display("FAIL deb_short_cap got=%h want 0", rd1);
    else pass_cnt++;
    address = 2'd0;
    in1[2] = 1'b1;
    tick(6);
    in1[2] = 1'b0;
    tick();
    total++;
    if (rd1 !== 32'h4) $display("FAIL deb_long_data got=%h want 00000004", rd1);
    else pass_cnt++;
    tick(10);
    rd(2'd3);
    total++;
    if (rd1 !== 32'h4) $display("FAIL deb_long_cap got=%h want 00000004", rd1);
    else pass_cnt++;
    rd(2'd0);
    total++;
    if (rd1 !== 32'h0) $display("FAIL deb_release got=%h want 0", rd1);
    else pass_cnt++;
  endtask

  task automatic test_any_edge_width;
    in0 = '0; in1 = '0; in2 = '0;
    do_reset();
    in2[7] = 1'b1;
    tick(4);
    rd(2'd3);
    total++;
    if (rd2 !== 32'h80) $display("FAIL any_rise got=%h want 00000080", rd2);
    else pass_cnt++;
    wr(2'd3, 32'hFFFFFFFF);
    rd(2'd3);
    total++;
    if (rd2 !== 32'h0) $display("FAIL any_clear got=%h want 0", rd2);
    else pass_cnt++;
    in2[7] = 1'b0;
    tick(4);
    rd(2'd3);
    total++;
    if (rd2 !== 32'h80) $display("FAIL any_fall got=%h want 00000080", rd2);
    else pass_cnt++;
    wr(2'd2, 32'hFFFFFFFF);
    rd(2'd2);
    total++;
    if (rd2 !== 32'h000000FF || rd0 !== 32'h0003FFFF)
      $display("FAIL mask_width got8=%h got18=%h want 000000ff/0003ffff", rd2, rd0);
    else pass_cnt++;
    total++;
    if (irq2 !== 1'b1) $display("FAIL any_irq got=%b want 1", irq2);
    else pass_cnt++;
    wr(2'd1, 32'hFFFFFFFF);
    rd(2'd1);
    total++;
    if (rd2 !== 32'h0) $display("FAIL reserved_read got=%h want 0", rd2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op;
    in0 = '0;
    do_reset();
    wr(2'd2, 32'h3);
    in0[1:0] = 2'b11;
    tick(5);
    rd(2'd3);
    total++;
    if (rd0 !== 32'h3 || irq0 !== 1'b1) $display("FAIL mid_pre cap=%h irq=%b want 3/1", rd0, irq0);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (irq0 !== 1'b0 || rd0 !== 32'h0) $display("FAIL mid_reset irq=%b rd=%h want 0/0", irq0, rd0);
    else pass_cnt++;
    tick(8);
    rd(2'd3);
    total++;
    if (rd0 !== 32'h0) $display("FAIL mid_cap_cleared got=%h want 0", rd0);
    else pass_cnt++;
    rd(2'd2);
    total++;
    if (rd0 !== 32'h0 || irq0 !== 1'b0) $display("FAIL mid_mask_cleared mask=%h irq=%b want 0/0", rd0, irq0);
    else pass_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    in0 = '0; in1 = '0; in2 = '0;
    test_reset();
    test_rising();
    test_set_clear_collision();
    test_debounce();
    test_any_edge_width();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
